// File: rtl/mem_arbiter.sv
// Round-robin N-master memory arbiter with registered slave strobes and return data.
// Define ARB_FIXED_PRIO_EN to give master 0 absolute priority over the round-robin masters.
module mem_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
   input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
   input  logic [N_MASTERS*2-1:0]      m_width,
   input  logic [N_MASTERS-1:0]        m_read,
   input  logic [N_MASTERS-1:0]        m_write,
   output logic [N_MASTERS-1:0]        m_ok,
   output logic [DATA_W-1:0]           m_rdata,
   output logic [ADDR_W-1:0]           s_addr,
   output logic [DATA_W-1:0]           s_wdata,
   output logic [1:0]                  s_width,
   output logic                        s_read,
   output logic                        s_write,
   input  logic [DATA_W-1:0]           s_rdata,
   input  logic                        s_ok,
   output logic [N_MASTERS-1:0]        grant,
   output logic                        busy
);

   localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     last;
   logic [IDX_W-1:0]     winner;
   logic                 win_vld;
   logic [N_MASTERS-1:0] req;

   assign req  = m_read | m_write;
   assign busy = (state != IDLE);

   // Scan from the farthest offset down so the nearest requester after 'last' wins.
   always_comb begin : pick
      int idx;
      idx     = 0;
      winner  = '0;
      win_vld = 1'b0;
      for (int off = N_MASTERS; off >= 1; off--) begin
         idx = (int'(last) + off) % N_MASTERS;
`ifdef ARB_FIXED_PRIO_EN
         if (idx != 0 && req[idx]) begin
`else
         if (req[idx]) begin
`endif
            winner  = IDX_W'(idx);
            win_vld = 1'b1;
         end
      end
`ifdef ARB_FIXED_PRIO_EN
      if (req[0]) begin
         winner  = '0;
         win_vld = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_vld) state_nxt = BUSY;
         BUSY:    if (s_ok)    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last    <= IDX_W'(N_MASTERS - 1);
         grant   <= '0;
         m_ok    <= '0;
         m_rdata <= '0;
         s_addr  <= '0;
         s_wdata <= '0;
         s_width <= '0;
         s_read  <= 1'b0;
         s_write <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  grant <= N_MASTERS'(1) << winner;
`ifdef ARB_FIXED_PRIO_EN
                  if (winner != '0) last <= winner;
`else
                  last <= winner;
`endif
                  s_addr  <= m_addr[int'(winner)*ADDR_W +: ADDR_W];
                  s_wdata <= m_wdata[int'(winner)*DATA_W +: DATA_W];
                  s_width <= m_width[int'(winner)*2 +: 2];
                  // A simultaneous read and write request is served as a write.
                  s_write <= m_write[winner];
                  s_read  <= m_read[winner] & ~m_write[winner];
               end
            end
            BUSY: begin
               if (s_ok) begin
                  m_rdata <= s_rdata;
                  s_read  <= 1'b0;
                  s_write <= 1'b0;
                  m_ok    <= grant;
               end
            end
            DONE: begin
               m_ok  <= '0;
               grant <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (4 masters): directed stimulus, a slave model and an m_ok monitor.
// Expected grant order follows ARB_FIXED_PRIO_EN when the bench is built with it.
module tb_mem_arbiter;

   localparam int N = 4;
   localparam logic [31:0] XMASK = 32'hDDAD_BEFF;

   logic            clk;
   logic            rst;
   logic [N*32-1:0] m_addr;
   logic [N*32-1:0] m_wdata;
   logic [N*2-1:0]  m_width;
   logic [N-1:0]    m_read;
   logic [N-1:0]    m_write;
   logic [N-1:0]    m_ok;
   logic [31:0]     m_rdata;
   logic [31:0]     s_addr;
   logic [31:0]     s_wdata;
   logic [1:0]      s_width;
   logic            s_read;
   logic            s_write;
   logic [31:0]     s_rdata;
   logic            s_ok;
   logic [N-1:0]    grant;
   logic            busy;

   logic [31:0] addr_r  [N];
   logic [31:0] wdata_r [N];
   logic [1:0]  width_r [N];

   assign m_addr  = {addr_r[3], addr_r[2], addr_r[1], addr_r[0]};
   assign m_wdata = {wdata_r[3], wdata_r[2], wdata_r[1], wdata_r[0]};
   assign m_width = {width_r[3], width_r[2], width_r[1], width_r[0]};

   mem_arbiter #(.N_MASTERS(N), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_width(m_width),
      .m_read(m_read), .m_write(m_write), .m_ok(m_ok), .m_rdata(m_rdata),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_width(s_width),
      .s_read(s_read), .s_write(s_write), .s_rdata(s_rdata), .s_ok(s_ok),
      .grant(grant), .busy(busy)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rd;
      logic        wr;
      logic [1:0]  width;
   } txn_t;

   typedef struct {
      int          m;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        wr;
      logic [1:0]  width;
      logic [31:0] rdata;
      bit          chk_rd;
      int          gap;
   } exp_t;

   txn_t mq [N][$];
   exp_t exp_q [$];

   int checks   = 0;
   int failures = 0;
   int lat      = 1;
   bit slave_en = 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic stim(input int m, input logic [31:0] a, input logic [31:0] wd,
                       input logic rd, input logic wr, input logic [1:0] w);
      txn_t t;
      t.addr = a; t.wdata = wd; t.rd = rd; t.wr = wr; t.width = w;
      mq[m].push_back(t);
   endtask

   task automatic expect_txn(input int m, input logic [31:0] a, input logic [31:0] wd,
                             input logic wr, input logic [1:0] w, input logic [31:0] rdat,
                             input bit chk_rd, input int gap);
      exp_t e;
      e.m = m; e.addr = a; e.wdata = wd; e.wr = wr; e.width = w;
      e.rdata = rdat; e.chk_rd = chk_rd; e.gap = gap;
      exp_q.push_back(e);
   endtask

   // Drives every queued master transaction; a master holds its request until it sees m_ok.
   task automatic run(input int budget);
      bit         active [N];
      logic [N-1:0] ok_seen;
      int         cyc;
      bit         pending;
      cyc = 0;
      for (int i = 0; i < N; i++) active[i] = 1'b0;
      forever begin
         pending = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!active[i] && mq[i].size() > 0) begin
               txn_t t;
               t = mq[i].pop_front();
               addr_r[i]  = t.addr;
               wdata_r[i] = t.wdata;
               width_r[i] = t.width;
               m_read[i]  = t.rd;
               m_write[i] = t.wr;
               active[i]  = 1'b1;
            end
            if (active[i]) pending = 1'b1;
         end
         if (!pending) break;
         @(negedge clk);
         ok_seen = m_ok;
         @(posedge clk);
         #1;
         cyc++;
         for (int i = 0; i < N; i++) begin
            if (active[i] && ok_seen[i]) begin
               active[i]  = 1'b0;
               m_read[i]  = 1'b0;
               m_write[i] = 1'b0;
            end
         end
         if (cyc > budget) begin
            checks++;
            failures++;
            $display("FAIL run_timeout actual=%0d required<=%0d cycles", cyc, budget);
            m_read  = '0;
            m_write = '0;
            for (int i = 0; i < N; i++) mq[i].delete();
            break;
         end
      end
   endtask

   // Slave model: s_ok 'lat' cycles after the strobe appears, read data = address ^ XMASK.
   initial begin : slave
      int cnt;
      bit prev;
      exp_t e;
      cnt = 0; prev = 1'b0;
      s_ok = 1'b0; s_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (s_ok) begin
            s_ok = 1'b0;
         end else if ((s_read || s_write) && slave_en) begin
            if (!prev && exp_q.size() > 0) begin
               e = exp_q[0];
               chk("s_grant", 32'(grant), 32'(1) << e.m);
               chk("s_addr", s_addr, e.addr);
               chk("s_write", 32'(s_write), 32'(e.wr));
               chk("s_read", 32'(s_read), 32'(!e.wr));
               chk("s_width", 32'(s_width), 32'(e.width));
               if (e.wr) chk("s_wdata", s_wdata, e.wdata);
            end
            if (cnt >= lat) begin
               s_ok    = 1'b1;
               s_rdata = s_addr ^ XMASK;
               cnt     = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
         prev = s_read || s_write;
      end
   end

   // Monitor: every m_ok pulse retires the oldest expected completion.
   initial begin : monitor
      logic [N-1:0] prev_ok;
      int cyc_now, last_ok;
      exp_t e;
      prev_ok = '0; cyc_now = 0; last_ok = 0;
      forever begin
         @(negedge clk);
         cyc_now++;
         if (!rst && m_ok != '0) begin
            chk("ok_pulse_width", 32'(prev_ok), 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_ok actual=%b required=none", m_ok);
            end else begin
               e = exp_q.pop_front();
               chk("grant_order", 32'(m_ok), 32'(1) << e.m);
               if (e.chk_rd) chk("m_rdata", m_rdata, e.rdata);
               if (e.gap > 0) chk("ok_spacing", 32'(cyc_now - last_ok), 32'(e.gap));
            end
            last_ok = cyc_now;
         end
         prev_ok = m_ok;
      end
   end

   initial begin
      rst = 1'b1;
      m_read = '0;
      m_write = '0;
      for (int i = 0; i < N; i++) begin
         addr_r[i] = '0; wdata_r[i] = '0; width_r[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_m_ok", 32'(m_ok), 32'd0);
      chk("rst_s_read", 32'(s_read), 32'd0);
      chk("rst_s_write", 32'(s_write), 32'd0);
      chk("rst_s_addr", s_addr, 32'd0);
      chk("rst_m_rdata", m_rdata, 32'd0);

      // Single read, slave answers one cycle after the strobe.
      lat = 1;
      stim(0, 32'h0300_0010, 32'h0, 1'b1, 1'b0, 2'd2);
      expect_txn(0, 32'h0300_0010, 32'h0, 1'b0, 2'd2, 32'hDEAD_BEEF, 1'b1, 0);
      run(50);

      // Contention between masters 0 and 1 with a zero-latency slave; master 0 was served last.
      lat = 0;
      stim(0, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 2'd2);
      stim(0, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 2'd2);
      stim(1, 32'h0000_0300, 32'h0, 1'b1, 1'b0, 2'd2);
      stim(1, 32'h0000_0400, 32'h0, 1'b1, 1'b0, 2'd2);
`ifdef ARB_FIXED_PRIO_EN
      expect_txn(0, 32'h0000_0100, 32'h0, 1'b0, 2'd2, 32'hDDAD_BFFF, 1'b1, 0);
      expect_txn(0, 32'h0000_0200, 32'h0, 1'b0, 2'd2, 32'hDDAD_BCFF, 1'b1, 3);
      expect_txn(1, 32'h0000_0300, 32'h0, 1'b0, 2'd2, 32'hDDAD_BDFF, 1'b1, 3);
      expect_txn(1, 32'h0000_0400, 32'h0, 1'b0, 2'd2, 32'hDDAD_BAFF, 1'b1, 3);
`else
      expect_txn(1, 32'h0000_0300, 32'h0, 1'b0, 2'd2, 32'hDDAD_BDFF, 1'b1, 0);
      expect_txn(0, 32'h0000_0100, 32'h0, 1'b0, 2'd2, 32'hDDAD_BFFF, 1'b1, 3);
      expect_txn(1, 32'h0000_0400, 32'h0, 1'b0, 2'd2, 32'hDDAD_BAFF, 1'b1, 3);
      expect_txn(0, 32'h0000_0200, 32'h0, 1'b0, 2'd2, 32'hDDAD_BCFF, 1'b1, 3);
`endif
      run(100);

      // Read and write together on master 1 is a write.
      stim(1, 32'h0000_0500, 32'h0000_1234, 1'b1, 1'b1, 2'd1);
      expect_txn(1, 32'h0000_0500, 32'h0000_1234, 1'b1, 2'd1, 32'h0, 1'b0, 0);
      run(50);

      // Master 2 served, then masters 1 and 3 together: 3 comes first.
      stim(2, 32'h0000_0600, 32'hCAFE_F00D, 1'b0, 1'b1, 2'd0);
      expect_txn(2, 32'h0000_0600, 32'hCAFE_F00D, 1'b1, 2'd0, 32'h0, 1'b0, 0);
      run(50);
      stim(1, 32'h0000_0700, 32'h0, 1'b1, 1'b0, 2'd2);
      stim(3, 32'h0000_0800, 32'h0, 1'b1, 1'b0, 2'd2);
      expect_txn(3, 32'h0000_0800, 32'h0, 1'b0, 2'd2, 32'hDDAD_B6FF, 1'b1, 0);
      expect_txn(1, 32'h0000_0700, 32'h0, 1'b0, 2'd2, 32'hDDAD_B9FF, 1'b1, 3);
      run(100);
      repeat (4) @(posedge clk);
      #1;
      chk("m_rdata_hold", m_rdata, 32'hDDAD_B9FF);
      chk("idle_busy", 32'(busy), 32'd0);

      // Reset while BUSY with a silent slave: access abandoned, round-robin pointer restored.
      slave_en = 1'b0;
      addr_r[0] = 32'h0000_0900;
      width_r[0] = 2'd2;
      m_read[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_busy", 32'(busy), 32'd1);
      chk("pre_rst_s_read", 32'(s_read), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_read[0] = 1'b0;
      chk("mid_rst_s_read", 32'(s_read), 32'd0);
      chk("mid_rst_grant", 32'(grant), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_m_ok", 32'(m_ok), 32'd0);
      chk("mid_rst_m_rdata", m_rdata, 32'd0);
      slave_en = 1'b1;
      stim(0, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 2'd2);
      stim(1, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 2'd2);
      expect_txn(0, 32'h0000_0100, 32'h0, 1'b0, 2'd2, 32'hDDAD_BFFF, 1'b1, 0);
      expect_txn(1, 32'h0000_0200, 32'h0, 1'b0, 2'd2, 32'hDDAD_BCFF, 1'b1, 3);
      run(100);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
